// File: rtl/sram_like_if.sv
// Sram-like bus between an L1 cache (master) and a memory responder (slave).
// One outstanding transaction: address phase closes on req & addr_ok,
// data phase closes on the data_ok pulse.
interface sram_like_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;
  logic        err;

  modport master (
    output req, wr, size, addr, wdata,
    input  rdata, addr_ok, data_ok, err
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output rdata, addr_ok, data_ok, err
  );
endinterface

// File: rtl/sram_like_ram_slave.sv
// Sram-like memory responder: word RAM with byte-masked writes, programmable
// address-phase and data-phase latency, one transaction outstanding, and a
// sticky misalignment flag.
module sram_like_ram_slave #(
  parameter int ADDR_WIDTH = 12,
  parameter int ADDR_LAT   = 0,
  parameter int DATA_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst,
  sram_like_if.slave  bus
);

  localparam logic [3:0] ALAT = 4'(ADDR_LAT);
  localparam logic [3:0] DLAT = 4'(DATA_LAT);

  typedef enum logic [1:0] {IDLE, AWAIT, DWAIT} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              acnt_q, acnt_d;
  logic [3:0]              dcnt_q, dcnt_d;
  logic                    addr_ok;
  logic                    data_ok_q, data_ok_d;
  logic [31:0]             rdata_q;
  logic                    err_q;

  // Transaction captured at the address handshake.
  logic                    wr_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [3:0]              mask_q;
  logic [31:0]             wdata_q;

  logic [ADDR_WIDTH-1:0]   idx_in;
  logic [3:0]              mask_in;
  logic                    misaligned;
  logic [ADDR_WIDTH-1:0]   rd_idx;
  logic                    rd_wr;
  logic                    commit_en;
  logic                    unused_addr_bits;

  logic [31:0]             mem [2**ADDR_WIDTH];

  // Bits above the word index alias onto the same word.
  assign idx_in           = bus.addr[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^bus.addr[31:ADDR_WIDTH+2];

  assign misaligned = ((bus.size == 2'd1) && bus.addr[0]) ||
                      (bus.size[1] && (bus.addr[1:0] != 2'b00));

  // Byte-lane mask derived from size and the low address bits.
  always_comb begin
    mask_in = 4'b1111;
    unique case (bus.size)
      2'd0:    mask_in = 4'b0001 << bus.addr[1:0];
      2'd1:    mask_in = bus.addr[1] ? 4'b1100 : 4'b0011;
      default: mask_in = 4'b1111;
    endcase
  end

  // Next-state, latency counters and the combinational addr_ok.
  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    acnt_d  = acnt_q;
    dcnt_d  = dcnt_q;
    addr_ok = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          if (ALAT == 4'd0) begin
            addr_ok = 1'b1;
            dcnt_d  = DLAT;
            state_d = DWAIT;
          end else begin
            acnt_d  = ALAT;
            state_d = AWAIT;
          end
        end
      end
      AWAIT: begin
        if (!bus.req) begin
          // Initiator withdrew the request; drop it without side effects.
          acnt_d  = 4'd0;
          state_d = IDLE;
        end else if (acnt_q == 4'd1) begin
          addr_ok = 1'b1;
          acnt_d  = 4'd0;
          dcnt_d  = DLAT;
          state_d = DWAIT;
        end else begin
          acnt_d = acnt_q - 4'd1;
        end
      end
      DWAIT: begin
        // The cycle with dcnt == 1 is the data_ok cycle; leave afterwards.
        dcnt_d = dcnt_q - 4'd1;
        if (dcnt_q == 4'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_ok_d = (state_d == DWAIT) && (dcnt_d == 4'd1);

  // With DATA_LAT = 1 the read happens on the handshake edge itself, before
  // the transaction registers hold it, so take it straight from the bus.
  assign rd_idx = addr_ok ? idx_in : idx_q;
  assign rd_wr  = addr_ok ? bus.wr : wr_q;

  // Control state, counters, data_ok pulse and sticky err.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acnt_q    <= 4'd0;
      dcnt_q    <= 4'd0;
      data_ok_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acnt_q    <= acnt_d;
      dcnt_q    <= dcnt_d;
      data_ok_q <= data_ok_d;
      if (addr_ok && misaligned) err_q <= 1'b1;
    end
  end

  // Capture the accepted transaction; only qualified by state, so no reset.
  always_ff @(posedge clk) begin
    if (addr_ok) begin
      wr_q    <= bus.wr;
      idx_q   <= idx_in;
      mask_q  <= mask_in;
      wdata_q <= bus.wdata;
    end
  end

  // Read data registered alongside data_ok and held until the next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 32'h0;
    end else if (data_ok_d && !rd_wr) begin
      rdata_q <= mem[rd_idx];
    end
  end

  // Writes commit on the edge closing the data_ok cycle, so a reset during
  // that cycle still cancels the store.
  assign commit_en = (state_q == DWAIT) && data_ok_q && wr_q && !rst;

  // Byte-masked RAM write.
  // NOTE: the RAM array has no reset; its contents survive rst and it can
  // map onto block RAM.
  always_ff @(posedge clk) begin
    if (commit_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mask_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign bus.addr_ok = addr_ok;
  assign bus.data_ok = data_ok_q;
  assign bus.rdata   = rdata_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_sram_like_ram_slave.sv
// Scoreboard bench for sram_like_ram_slave: two instances, one with
// ADDR_LAT=0/DATA_LAT=1 and one with ADDR_LAT=2/DATA_LAT=3. Stimulus pushes
// the expected completion (cycle, rdata, err); a monitor pops it on data_ok.
module tb_sram_like_ram_slave;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cycle;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_d   [2];
  logic        req_d   [2];
  logic        wr_d    [2];
  logic [1:0]  size_d  [2];
  logic [31:0] addr_d  [2];
  logic [31:0] wdata_d [2];
  logic        aok_o   [2];
  logic        dok_o   [2];
  logic [31:0] rdata_o [2];
  logic        err_o   [2];

  exp_t        sb [2][$];
  int          dok_cnt [2];
  logic [31:0] last_read [2];
  int          checks = 0;
  int          failures = 0;

  sram_like_if bus0 ();
  sram_like_if bus1 ();

  assign bus0.req = req_d[0];  assign bus0.wr = wr_d[0];
  assign bus0.size = size_d[0]; assign bus0.addr = addr_d[0];
  assign bus0.wdata = wdata_d[0];
  assign bus1.req = req_d[1];  assign bus1.wr = wr_d[1];
  assign bus1.size = size_d[1]; assign bus1.addr = addr_d[1];
  assign bus1.wdata = wdata_d[1];

  assign aok_o[0] = bus0.addr_ok; assign dok_o[0] = bus0.data_ok;
  assign rdata_o[0] = bus0.rdata; assign err_o[0] = bus0.err;
  assign aok_o[1] = bus1.addr_ok; assign dok_o[1] = bus1.data_ok;
  assign rdata_o[1] = bus1.rdata; assign err_o[1] = bus1.err;

  sram_like_ram_slave #(.ADDR_WIDTH(12), .ADDR_LAT(0), .DATA_LAT(1)) dut0 (
    .clk(clk), .rst(rst_d[0]), .bus(bus0.slave)
  );

  sram_like_ram_slave #(.ADDR_WIDTH(12), .ADDR_LAT(2), .DATA_LAT(3)) dut1 (
    .clk(clk), .rst(rst_d[1]), .bus(bus1.slave)
  );

  function automatic int alat(input int i);
    return (i == 0) ? 0 : 2;
  endfunction

  function automatic int dlat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every data_ok must match the oldest outstanding expectation.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (dok_o[i] === 1'b1) begin
        dok_cnt[i]++;
        if (sb[i].size() == 0) begin
          check($sformatf("dut%0d_data_ok_expected", i), 32'(sb[i].size() != 0), 32'd1);
        end else begin
          exp_t e;
          e = sb[i].pop_front();
          check($sformatf("dut%0d_data_ok_cycle", i), 32'(cyc), 32'(e.cycle));
          check($sformatf("dut%0d_rdata", i), rdata_o[i], e.rdata);
          check($sformatf("dut%0d_err", i), 32'(err_o[i]), 32'(e.err));
        end
      end
    end
  end

  task automatic push_exp(input int i, input logic w, input logic [31:0] rd, input logic e);
    exp_t x;
    if (!w) last_read[i] = rd;
    x.rdata = last_read[i];
    x.err   = e;
    x.cycle = cyc + dlat(i);
    sb[i].push_back(x);
  endtask

  task automatic drain(input int i);
    for (int k = 0; k < 40; k++) begin
      if (sb[i].size() == 0) break;
      @(negedge clk);
    end
    check($sformatf("dut%0d_drain", i), 32'(sb[i].size()), 32'd0);
  endtask

  task automatic drive(input int i, input logic w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    req_d[i] = 1'b1; wr_d[i] = w; size_d[i] = sz; addr_d[i] = a; wdata_d[i] = wd;
  endtask

  // Full transaction with address-latency check and scoreboard push.
  task automatic run_txn(input int i, input logic w, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err);
    int   start;
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    drive(i, w, sz, a, wd);
    start = cyc;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (aok_o[i] === 1'b1) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    check($sformatf("dut%0d_addr_ok_seen", i), 32'(got), 32'd1);
    if (got) begin
      check($sformatf("dut%0d_addr_ok_latency", i), 32'(cyc - start), 32'(alat(i)));
      push_exp(i, w, exp_rd, exp_err);
    end
    @(posedge clk); #1;
    req_d[i] = 1'b0;
    drain(i);
  endtask

  task automatic reset_dut(input int i, input int n);
    @(posedge clk); #1;
    rst_d[i] = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst_d[i] = 1'b0;
    last_read[i] = 32'h0;
  endtask

  task automatic check_reset(input int i, input string tag);
    @(negedge clk);
    check($sformatf("dut%0d_%s_addr_ok", i, tag), 32'(aok_o[i]), 32'd0);
    check($sformatf("dut%0d_%s_data_ok", i, tag), 32'(dok_o[i]), 32'd0);
    check($sformatf("dut%0d_%s_rdata", i, tag), rdata_o[i], 32'h0);
    check($sformatf("dut%0d_%s_err", i, tag), 32'(err_o[i]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=%0d expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int first_ok, second_ok, n, base;
    logic got;
    for (int i = 0; i < 2; i++) begin
      rst_d[i] = 1'b1; req_d[i] = 1'b0; wr_d[i] = 1'b0; size_d[i] = 2'd0;
      addr_d[i] = 32'h0; wdata_d[i] = 32'h0; dok_cnt[i] = 0; last_read[i] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_d[0] = 1'b0; rst_d[1] = 1'b0;
    check_reset(0, "por");
    check_reset(1, "por");

    // ---- dut0: ADDR_LAT=0, DATA_LAT=1 ----
    run_txn(0, 1, 2'd2, 32'h10,   32'h12345678, 32'h0,        0);
    run_txn(0, 0, 2'd2, 32'h10,   32'h0,        32'h12345678, 0);
    run_txn(0, 1, 2'd2, 32'h10,   32'h11223344, 32'h0,        0);
    run_txn(0, 1, 2'd0, 32'h13,   32'hABABABAB, 32'h0,        0);
    run_txn(0, 0, 2'd2, 32'h10,   32'h0,        32'hAB223344, 0);
    run_txn(0, 1, 2'd2, 32'h10,   32'h11223344, 32'h0,        0);
    run_txn(0, 1, 2'd1, 32'h12,   32'hBEEFBEEF, 32'h0,        0);
    run_txn(0, 0, 2'd2, 32'h10,   32'h0,        32'hBEEF3344, 0);
    run_txn(0, 1, 2'd2, 32'h10,   32'h11223344, 32'h0,        0);
    run_txn(0, 1, 2'd1, 32'h10,   32'hBEEFBEEF, 32'h0,        0);
    run_txn(0, 0, 2'd2, 32'h10,   32'h0,        32'h1122BEEF, 0);
    run_txn(0, 1, 2'd0, 32'h11,   32'hCDCDCDCD, 32'h0,        0);
    run_txn(0, 0, 2'd2, 32'h10,   32'h0,        32'h1122CDEF, 0);
    run_txn(0, 1, 2'd3, 32'h14,   32'hA5A5A5A5, 32'h0,        0);
    run_txn(0, 0, 2'd2, 32'h14,   32'h0,        32'hA5A5A5A5, 0);
    run_txn(0, 1, 2'd2, 32'h4010, 32'h0BADC0DE, 32'h0,        0);
    run_txn(0, 0, 2'd2, 32'h10,   32'h0,        32'h0BADC0DE, 0);

    // Reset during the data_ok cycle cancels the store.
    run_txn(0, 1, 2'd2, 32'h30,   32'h5555AAAA, 32'h0,        0);
    @(posedge clk); #1;
    drive(0, 1, 2'd2, 32'h30, 32'h77777777);
    @(negedge clk);
    check("dut0_rstdok_addr_ok", 32'(aok_o[0]), 32'd1);
    if (aok_o[0] === 1'b1) push_exp(0, 1, 32'h0, 0);
    @(posedge clk); #1;
    req_d[0] = 1'b0;
    rst_d[0] = 1'b1;
    @(posedge clk); #1;
    rst_d[0] = 1'b0;
    last_read[0] = 32'h0;
    drain(0);
    check_reset(0, "rstdok");
    run_txn(0, 0, 2'd2, 32'h30,   32'h0,        32'h5555AAAA, 0);

    // Misaligned halfword: err sticks through aligned accesses until rst.
    run_txn(0, 1, 2'd2, 32'h10,   32'h11223344, 32'h0,        0);
    run_txn(0, 1, 2'd1, 32'h11,   32'hBEEFBEEF, 32'h0,        1);
    run_txn(0, 0, 2'd2, 32'h10,   32'h0,        32'h1122BEEF, 1);
    run_txn(0, 0, 2'd2, 32'h14,   32'h0,        32'hA5A5A5A5, 1);
    reset_dut(0, 1);
    check_reset(0, "errclr");

    // ---- dut1: ADDR_LAT=2, DATA_LAT=3 ----
    run_txn(1, 1, 2'd2, 32'h20,   32'h00000000, 32'h0,        0);

    // req held continuously: write then back-to-back read of the same word.
    first_ok = -1; second_ok = -1; n = 0;
    @(posedge clk); #1;
    drive(1, 1, 2'd2, 32'h40, 32'hCAFEF00D);
    base = cyc;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (aok_o[1] === 1'b1) begin
        n++;
        if (n == 1) begin
          first_ok = cyc - base;
          push_exp(1, 1, 32'h0, 0);
        end else begin
          second_ok = cyc - base;
          push_exp(1, 0, 32'hCAFEF00D, 0);
        end
      end
      if (n == 2) break;
      @(posedge clk); #1;
      if (n == 1) wr_d[1] = 1'b0;
    end
    @(posedge clk); #1;
    req_d[1] = 1'b0;
    check("dut1_first_addr_ok_cycle", 32'(first_ok), 32'd2);
    check("dut1_second_addr_ok_cycle", 32'(second_ok), 32'd8);
    drain(1);

    // Reset in the first DWAIT cycle of a write abandons it.
    base = dok_cnt[1];
    @(posedge clk); #1;
    drive(1, 1, 2'd2, 32'h20, 32'hDEADBEEF);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (aok_o[1] === 1'b1) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("dut1_rstmid_addr_ok_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    req_d[1] = 1'b0;
    rst_d[1] = 1'b1;
    @(posedge clk); #1;
    rst_d[1] = 1'b0;
    last_read[1] = 32'h0;
    check_reset(1, "rstmid");
    repeat (6) @(negedge clk);
    check("dut1_rstmid_no_data_ok", 32'(dok_cnt[1] - base), 32'd0);
    run_txn(1, 0, 2'd2, 32'h20,   32'h0,        32'h00000000, 0);

    repeat (3) @(posedge clk);
    check("dut0_sb_empty", 32'(sb[0].size()), 32'd0);
    check("dut1_sb_empty", 32'(sb[1].size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_like_ram_slave.md
# sram_like_ram_slave

Responder end of the sram-like memory interface that the L1 caches drive as initiators. It accepts address handshakes, holds one transaction outstanding, and returns `data_ok` after a programmable latency. Storage is an on-chip word RAM with byte-masked writes. It serves as the memory model behind `d_cache`/`i_cache` in block-level benches and as a small scratchpad on the FPGA build.

## Interface
- `ADDR_WIDTH`, 12: word-index width; RAM holds 2^ADDR_WIDTH 32-bit words.
- `ADDR_LAT`, 0: extra cycles `req` must be held before `addr_ok`. Legal range 0..15.
- `DATA_LAT`, 1: cycles from address handshake to `data_ok`. Legal range 1..15.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `req` in 1: request. The initiator holds it high until `addr_ok`.
- `wr` in 1: 1 = write, 0 = read. Valid while `req` is high.
- `size` in 2: 0 = byte, 1 = halfword, 2 = word, 3 = treated as word.
- `addr` in 32: byte address. `addr[ADDR_WIDTH+1:2]` selects the word; upper bits are ignored.
- `wdata` in 32: write data, lane-aligned as sent by the core.
- `rdata` out 32: read data, valid in the `data_ok` cycle.
- `addr_ok` out 1: address accepted. Combinational, single-cycle.
- `data_ok` out 1: transaction complete. Registered, single-cycle pulse.
- `err` out 1: sticky misalignment flag.

## Operation
- **FSM states:**
  - IDLE: no transaction.
  - AWAIT: `req` is high and the ADDR_LAT delay is counting.
  - DWAIT: a transaction is outstanding.
- **IDLE:**
  - If `req` is high and ADDR_LAT = 0, `addr_ok` = 1 in the same cycle and the next state is DWAIT.
  - If `req` is high and ADDR_LAT > 0, load `acnt` = ADDR_LAT and go to AWAIT.
- **AWAIT:**
  - `acnt` decrements each cycle.
  - `addr_ok` = `req` & (`acnt` == 1). A handshake moves to DWAIT.
  - If `req` drops, return to IDLE with no side effects. This is a protocol violation, which the block tolerates.
- **Handshake:** occurs when `req` & `addr_ok`. At that edge, latch `wr`, word index, byte mask and `wdata`, and load `dcnt` = DATA_LAT.
- **DWAIT:**
  - `dcnt` decrements each cycle. `addr_ok` is forced to 0, giving exactly one outstanding transaction.
  - When `dcnt` reaches 0, pulse `data_ok` and return to IDLE.
  - On a read, register `rdata` = `mem[idx_q]` in the same cycle that `data_ok` is registered.
  - On a write, commit the masked write to `mem[idx_q]` at that edge.
- **Byte mask:**
  - size 0: one-hot on `addr[1:0]` (00 → 0001, 11 → 1000).
  - size 1: `addr[1]` ? 1100 : 0011.
  - size 2 or 3: 1111.
  - New word = (old & ~mask32) | (`wdata` & mask32), where mask32 expands each mask bit to 8 bits.
- **Reads:** always return the full word. The core extracts the required lanes.
- **`err`:** set at the handshake edge if size = 1 with `addr[0]` = 1, or size ≥ 2 with `addr[1:0]` ≠ 0. It stays set until reset. The access still proceeds with the mask defined above.

## Timing
- **Reset values:** `addr_ok` = 0, `data_ok` = 0, `rdata` = 0, `err` = 0, state IDLE, both counters 0. RAM contents are not reset and are retained across reset.
- **`addr_ok` timing:** with `req` first high in cycle R, `addr_ok` is high in cycle R + ADDR_LAT.
- **`data_ok` timing:** with the handshake in cycle T, `data_ok` is high in cycle T + DATA_LAT only.
- **`rdata` hold:** `rdata` is stable from the `data_ok` cycle until the next read's `data_ok` cycle. Writes do not change `rdata`.
- **Next request:** the earliest next `addr_ok` is cycle T + DATA_LAT + 1, counted from a `req` held high through DWAIT.
  - AWAIT counting for the next request does not start before IDLE, so its `addr_ok` falls at IDLE entry + ADDR_LAT.
- **Read-after-write:** a read to the same word handshaked after a write's `data_ok` returns the written data.
- **Reset mid-operation:** a transaction in AWAIT or DWAIT is abandoned.
  - No `data_ok` is issued and no RAM write occurs.
  - A reset in the `data_ok` cycle still suppresses the write commit. The reset wins over the pending edge.
- **Wrap:** address bits above `ADDR_WIDTH+1` alias. For example, with ADDR_WIDTH = 12, 0x0000_4010 and 0x0000_0010 hit the same word.

## Test plan
- **Word write then read** (ADDR_LAT = 0, DATA_LAT = 1):
  - Stimulus: write word 0x12345678 to 0x10, then read 0x10.
  - Response: `addr_ok` in the same cycle as `req`, `data_ok` one cycle later, read `rdata` = 0x12345678, `err` = 0.
- **Byte store:**
  - Stimulus: preload 0x11223344 at 0x10; write size 0 at 0x13 with `wdata` = 0xABABABAB; then read 0x10.
  - Response: 0xAB223344.
- **Halfword store:**
  - Stimulus: preload 0x11223344; write size 1 at 0x12 with `wdata` = 0xBEEFBEEF; then read.
  - Response: 0xBEEF3344. With `addr` = 0x10 instead, the read returns 0x1122BEEF.
- **Latencies** (ADDR_LAT = 2, DATA_LAT = 3):
  - Stimulus: `req` high from cycle 0 and held; a second `req` follows immediately after `addr_ok`.
  - Response: `addr_ok` in cycle 2 and `data_ok` in cycle 5. The second request's `addr_ok` does not occur before cycle 8, and no `addr_ok` occurs in cycles 3–5.
- **Reset mid-write:**
  - Stimulus: write 0xDEADBEEF to 0x20 (old value 0x0), asserting `rst` in the DWAIT cycle; then read 0x20.
  - Response: no `data_ok`, and the read returns 0x00000000.
- **Misaligned access:**
  - Stimulus: halfword write at 0x11.
  - Response: `err` = 1 from the cycle after the handshake and held through later aligned accesses. It clears only on `rst`.
